single_vector_load: RTL and testbench
=====================================

# single_vector_load

Serial-to-vector loader that sits directly upstream of the single-precision vector max tree. It accepts one 32-bit IEEE-754 single per cycle over a valid/ready handshake and assembles WIDTH elements into a vector. It presents the vector with a valid flag, in the `vector_a[WIDTH]` shape the tree consumes. Short vectors, terminated by `in_last`, are padded with their final element so the tree's max result is unaffected.

## Interface
- `WIDTH`, 16, elements per output vector; must be ≥ 2.
- `clk`  input  1  clock; all logic on the rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `in_valid`  input  1  `a` / `in_last` carry an element.
- `in_ready`  output  1  loader can accept an element this cycle.
- `a`  input  32  single-precision element; data is not interpreted.
- `in_last`  input  1  the element is the final one of the current vector.
- `out_valid`  output  1  `vector_c` / `out_count` hold a complete vector.
- `out_ready`  input  1  downstream takes the vector. The max tree has no backpressure, so tie this high there.
- `vector_c`  output  32 × [WIDTH]  assembled vector; index 0 is the first element accepted.
- `out_count`  output  $clog2(WIDTH+1)  number of real (unpadded) elements, 1..WIDTH.

## Operation
- Two storage levels:
  - fill buffer: WIDTH × 32, plus write index `idx` (0..WIDTH-1);
  - output register: `vector_c`, `out_count`, `out_valid`.
- Fill FSM states:
  - FILL: `in_ready` = 1.
  - PEND: the fill buffer is complete but not yet transferred; `in_ready` = 0.
- Accept occurs when `in_valid && in_ready`. On accept, write `a` to `fill[idx]`.
- The vector completes on accept when `idx == WIDTH-1` or `in_last` = 1.
- On completion:
  - elements `idx+1..WIDTH-1` are written with the same `a` (pad with last);
  - captured count = `idx+1`;
  - `idx` returns to 0.
- Transfer moves the fill buffer and count into the output register and sets `out_valid` = 1.
  - Transfer is allowed when the output register is free: `!out_valid` or `out_ready` in the same cycle.
  - If completion and a free output register coincide, transfer happens on the completing edge. The padded value goes directly into `vector_c`, with no stop in PEND.
  - Otherwise the FSM enters PEND and transfers on the first edge where the output register is free, then returns to FILL.
- Drain:
  - `out_valid && out_ready` with no simultaneous transfer clears `out_valid`.
  - Drain with a simultaneous transfer keeps `out_valid` = 1 with the new contents.
- While `out_valid && !out_ready`, `vector_c` and `out_count` are held stable.
- `in_last` is ignored unless accepted. A vector always contains ≥ 1 element.
- While `in_ready` = 0, `a` and `in_valid` are ignored; the upstream source must hold them.

## Timing
- Reset values:
  - `out_valid` = 0, `vector_c` = all 0, `out_count` = 0;
  - `idx` = 0, state FILL, so `in_ready` = 1 while `rst` is deasserted;
  - fill buffer contents are don't-care.
- Latency: completing accept at edge t gives `out_valid` = 1 after edge t when the output register is free.
- Sustained throughput: one element per cycle with `out_ready` = 1, with no bubbles between vectors.
- Backpressure:
  - with `out_ready` = 0 and `out_valid` = 1, one further vector is accepted, then `in_ready` drops;
  - `in_ready` rises the cycle after the drain edge.
- Reset mid-fill or mid-PEND discards partial and pending data, and any held output. There is no output until WIDTH new elements, or an `in_last`, are accepted.

## Test plan
- WIDTH=16, `out_ready`=1:
  - stimulus: elements 0x3F800000+i for i=0..15, back to back;
  - required: single-cycle `out_valid` after the 16th edge, `vector_c[i]` = 0x3F800000+i, `out_count` = 16, `in_ready` never low.
- Short vector:
  - stimulus: 5 elements 0x40000000..0x40000004, `in_last` on the 5th;
  - required: `vector_c[0..4]` = inputs, `vector_c[5..15]` = 0x40000004, `out_count` = 5;
  - follow-on: the next element lands in index 0.
- Backpressure:
  - stimulus: `out_ready`=0; stream 40 elements with `in_valid` held;
  - required:
    - first vector held stable;
    - second vector accepted, then `in_ready`=0 with element 33 held;
    - raising `out_ready` drains vectors 1, 2 in order;
    - element 33 becomes `vector_c[0]` of vector 3, with no loss or duplication.
- Simultaneous drain and completion:
  - stimulus: `out_valid`=1 and `out_ready`=1 on the same edge as the completing accept;
  - required: `out_valid` stays 1 with new contents, `in_ready` stays 1.
- Reset:
  - stimulus: assert `rst` asynchronously after 7 elements, mid-cycle;
  - required: `out_valid`=0 and `vector_c`=0 immediately;
  - then 16 new elements produce exactly those 16 with `out_count` = 16.
- WIDTH=5:
  - stimulus: 12 elements, `in_last` on the 12th;
  - required: vectors {1..5}, {6..10}, {11,12,12,12,12} with `out_count` 5, 5, 2.

Source files
------------

// File: rtl/single_vector_load_if.sv
// Handshake bundle between a serial element source, the vector loader and the
// downstream max tree: element stream in, assembled vector out.
interface single_vector_load_if #(
    parameter int WIDTH = 16
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic              in_valid;
    logic              in_ready;
    logic [31:0]       a;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       vector_c [WIDTH];
    logic [CNT_W-1:0]  out_count;

    modport master (
        output in_valid, a, in_last, out_ready,
        input  in_ready, out_valid, vector_c, out_count
    );

    modport slave (
        input  in_valid, a, in_last, out_ready,
        output in_ready, out_valid, vector_c, out_count
    );
endinterface

// File: rtl/single_vector_load.sv
// Serial-to-vector loader: gathers WIDTH singles (or fewer, ended by in_last,
// padded with the final element) into a fill buffer, then an output register.
module single_vector_load #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    single_vector_load_if.slave bus
);
    localparam int DATA_W = 32;
    localparam int IDX_W  = $clog2(WIDTH);
    localparam int CNT_W  = $clog2(WIDTH + 1);

    typedef enum logic {FILL, PEND} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] fill_q [WIDTH];
    logic [DATA_W-1:0] fill_d [WIDTH];
    logic [CNT_W-1:0]  fill_cnt_q, fill_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] vec_q [WIDTH];
    logic [DATA_W-1:0] vec_d [WIDTH];
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              in_ready;
    logic              accept;
    logic              complete;
    logic              out_free;
    logic [CNT_W-1:0]  comp_cnt;

    assign in_ready = (state_q == FILL);
    assign accept   = bus.in_valid && in_ready;
    assign complete = accept && ((idx_q == IDX_W'(WIDTH - 1)) || bus.in_last);
    assign out_free = !out_valid_q || bus.out_ready;
    assign comp_cnt = CNT_W'(idx_q) + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        fill_d      = fill_q;
        fill_cnt_d  = fill_cnt_q;
        out_valid_d = out_valid_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;

        // On completion the tail slots take the same element so the max is unchanged.
        if (accept) begin
            for (int i = 0; i < WIDTH; i++) begin
                if ((IDX_W'(i) == idx_q) || (complete && (IDX_W'(i) > idx_q))) begin
                    fill_d[i] = bus.a;
                end
            end
            idx_d = complete ? '0 : idx_q + IDX_W'(1);
        end

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (state_q == PEND) begin
            if (out_free) begin
                vec_d       = fill_q;
                cnt_d       = fill_cnt_q;
                out_valid_d = 1'b1;
                state_d     = FILL;
            end
        end else if (complete) begin
            // Free output register: bypass PEND and load the padded vector directly.
            if (out_free) begin
                vec_d       = fill_d;
                cnt_d       = comp_cnt;
                out_valid_d = 1'b1;
            end else begin
                fill_cnt_d  = comp_cnt;
                state_d     = PEND;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                vec_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            vec_q       <= vec_d;
        end
    end

    // Fill buffer contents are meaningless until written, so they carry no reset.
    always_ff @(posedge clk) begin
        fill_q     <= fill_d;
        fill_cnt_q <= fill_cnt_d;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.vector_c  = vec_q;
    assign bus.out_count = cnt_q;
endmodule

// File: tb/tb_single_vector_load.sv
// Bench for single_vector_load: WIDTH=5 cycle table plus WIDTH=16 directed
// sequences and random traffic against a queue-based vector model.
module tb_single_vector_load;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    single_vector_load_if #(.WIDTH(16)) if16();
    single_vector_load_if #(.WIDTH(5))  if5();

    single_vector_load #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(if16));
    single_vector_load #(.WIDTH(5))  u5  (.clk(clk), .rst(rst), .bus(if5));

    int n_tests = 0;
    int n_fail  = 0;
    int stalls  = 0;
    int acc16   = 0;
    bit rnd_mode = 0;

    typedef struct packed {
        logic [15:0][31:0] v;
        logic [7:0]        cnt;
    } vec_t;

    vec_t        exp_q [$];
    logic [31:0] cur [$];

    typedef struct {
        bit          iv;
        logic [31:0] a;
        bit          last;
        bit          ordy;
        bit          e_ir;
        bit          e_ov;
        int          e_cnt;
        logic [31:0] e_v0;
        logic [31:0] e_vl;
    } row_t;

    row_t tbl [$];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_row(input bit iv, input logic [31:0] a, input bit last, input bit ordy,
                           input bit e_ir, input bit e_ov, input int e_cnt,
                           input logic [31:0] e_v0, input logic [31:0] e_vl);
        row_t r;
        r.iv = iv; r.a = a; r.last = last; r.ordy = ordy;
        r.e_ir = e_ir; r.e_ov = e_ov; r.e_cnt = e_cnt; r.e_v0 = e_v0; r.e_vl = e_vl;
        tbl.push_back(r);
    endtask

    // Reference: group accepted elements into vectors of up to 16, pad with the last one.
    task automatic model_push(input logic [31:0] d, input bit l);
        vec_t e;
        cur.push_back(d);
        acc16++;
        if (cur.size() == 16 || l) begin
            e.cnt = 8'(cur.size());
            for (int i = 0; i < 16; i++) begin
                e.v[i] = (i < cur.size()) ? cur[i] : cur[cur.size() - 1];
            end
            exp_q.push_back(e);
            cur.delete();
        end
    endtask

    // Called and returns at posedge+1; the element is accepted on the edge it waits for.
    task automatic send16(input logic [31:0] d, input bit l);
        bit ok = 0;
        if16.in_valid = 1'b1;
        if16.a        = d;
        if16.in_last  = l;
        for (int w = 0; w < 500 && !ok; w++) begin
            @(negedge clk);
            if (if16.in_ready) ok = 1;
            else stalls++;
            @(posedge clk);
            #1;
            if (rnd_mode) if16.out_ready = ($urandom_range(0, 3) != 0);
        end
        if (!ok) chk("send_timeout", 80'(0), 80'(1));
        else model_push(d, l);
        if16.in_valid = 1'b0;
        if16.in_last  = 1'b0;
    endtask

    // Scoreboard and hold-stability monitor on the 16-wide instance.
    initial begin
        vec_t        e;
        logic [31:0] held [16];
        logic [7:0]  held_cnt;
        bit          hold_v;
        int          bad;
        hold_v = 0;
        held_cnt = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_v = 0;
            end else begin
                if (hold_v && if16.out_valid) begin
                    bad = 0;
                    for (int i = 15; i >= 0; i--) if (if16.vector_c[i] !== held[i]) bad = i;
                    chk("hold_vec", 80'(if16.vector_c[bad]), 80'(held[bad]));
                    chk("hold_cnt", 80'(if16.out_count), 80'(held_cnt));
                end
                if (if16.out_valid && if16.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected_vector", 80'(1), 80'(0));
                    end else begin
                        e = exp_q.pop_front();
                        bad = 0;
                        for (int i = 15; i >= 0; i--) if (if16.vector_c[i] !== e.v[i]) bad = i;
                        chk("sb_vec", 80'(if16.vector_c[bad]), 80'(e.v[bad]));
                        chk("sb_cnt", 80'(if16.out_count), 80'(e.cnt));
                    end
                end
                hold_v = if16.out_valid && !if16.out_ready;
                if (hold_v) begin
                    for (int i = 0; i < 16; i++) held[i] = if16.vector_c[i];
                    held_cnt = 8'(if16.out_count);
                end
            end
        end
    end

    initial begin
        logic [79:0] act, exp;
        int bad;
        rst = 1'b0;
        if16.in_valid = 0; if16.a = '0; if16.in_last = 0; if16.out_ready = 1;
        if5.in_valid  = 0; if5.a  = '0; if5.in_last  = 0; if5.out_ready  = 1;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_out_valid", 80'(if16.out_valid), 80'(0));
        chk("rst_out_count", 80'(if16.out_count), 80'(0));
        chk("rst_in_ready", 80'(if16.in_ready), 80'(1));
        bad = 0;
        for (int i = 15; i >= 0; i--) if (if16.vector_c[i] !== 32'h0) bad = i;
        chk("rst_vector_c", 80'(if16.vector_c[bad]), 80'(0));

        // WIDTH=5 cycle table: values are the state after each edge.
        for (int k = 1; k <= 4; k++) add_row(1, 32'(k), 0, 1, 1, 0, 0, 0, 0);
        add_row(1, 5, 0, 1, 1, 1, 5, 1, 5);
        for (int k = 6; k <= 9; k++) add_row(1, 32'(k), 0, 1, 1, 0, 5, 1, 5);
        add_row(1, 10, 0, 1, 1, 1, 5, 6, 10);
        add_row(1, 11, 0, 1, 1, 0, 5, 6, 10);
        add_row(1, 12, 1, 1, 1, 1, 2, 11, 12);
        add_row(0, 0, 0, 1, 1, 0, 2, 11, 12);
        for (int k = 20; k <= 23; k++) add_row(1, 32'(k), 0, 0, 1, 0, 2, 11, 12);
        add_row(1, 24, 0, 0, 1, 1, 5, 20, 24);
        for (int k = 30; k <= 33; k++) add_row(1, 32'(k), 0, 0, 1, 1, 5, 20, 24);
        add_row(1, 34, 0, 0, 0, 1, 5, 20, 24);
        add_row(1, 40, 1, 0, 0, 1, 5, 20, 24);
        add_row(1, 40, 1, 1, 1, 1, 5, 30, 34);
        add_row(1, 40, 1, 1, 1, 1, 1, 40, 40);
        add_row(0, 0, 0, 1, 1, 0, 1, 40, 40);

        for (int r = 0; r < tbl.size(); r++) begin
            if5.in_valid  = tbl[r].iv;
            if5.a         = tbl[r].a;
            if5.in_last   = tbl[r].last;
            if5.out_ready = tbl[r].ordy;
            @(posedge clk);
            #1;
            act = 80'({if5.in_ready, if5.out_valid, 8'(if5.out_count), if5.vector_c[0], if5.vector_c[4]});
            exp = 80'({tbl[r].e_ir, tbl[r].e_ov, 8'(tbl[r].e_cnt), tbl[r].e_v0, tbl[r].e_vl});
            chk($sformatf("w5_row%0d", r), act, exp);
        end
        if5.in_valid = 0;

        // Full vector back to back, single-cycle out_valid.
        stalls = 0;
        for (int i = 0; i < 16; i++) send16(32'h3F80_0000 + 32'(i), 0);
        chk("full_out_valid", 80'(if16.out_valid), 80'(1));
        chk("full_out_count", 80'(if16.out_count), 80'(16));
        for (int i = 0; i < 16; i++)
            chk($sformatf("full_vc%0d", i), 80'(if16.vector_c[i]), 80'(32'h3F80_0000 + 32'(i)));
        chk("full_no_stall", 80'(stalls), 80'(0));
        @(posedge clk);
        #1;
        chk("full_valid_one_cycle", 80'(if16.out_valid), 80'(0));

        // Short vector padded with its final element, then a fresh vector.
        for (int i = 0; i < 5; i++) send16(32'h4000_0000 + 32'(i), i == 4);
        chk("short_out_count", 80'(if16.out_count), 80'(5));
        for (int i = 0; i < 16; i++)
            chk($sformatf("short_vc%0d", i), 80'(if16.vector_c[i]),
                80'(32'h4000_0000 + 32'((i < 5) ? i : 4)));
        for (int i = 0; i < 16; i++) send16(32'hA000_0000 + 32'(i), 0);
        chk("follow_vc0", 80'(if16.vector_c[0]), 80'(32'hA000_0000));

        // Backpressure: two vectors accepted, then element 33 held until drain.
        @(posedge clk);
        #1;
        if16.out_ready = 0;
        acc16 = 0;
        fork
            begin
                for (int k = 0; k < 40; k++) send16(32'hB000_0000 + 32'(k), 0);
            end
            begin
                repeat (50) @(posedge clk);
                #1;
                chk("bp_accepted", 80'(acc16), 80'(32));
                chk("bp_in_ready_low", 80'(if16.in_ready), 80'(0));
                chk("bp_out_valid", 80'(if16.out_valid), 80'(1));
                chk("bp_vec1_vc0", 80'(if16.vector_c[0]), 80'(32'hB000_0000));
                if16.out_ready = 1;
            end
        join
        for (int k = 40; k < 48; k++) send16(32'hB000_0000 + 32'(k), 0);
        chk("bp_vec3_vc0", 80'(if16.vector_c[0]), 80'(32'hB000_0020));
        chk("bp_vec3_valid", 80'(if16.out_valid), 80'(1));
        repeat (3) @(posedge clk);
        #1;
        chk("bp_drained", 80'(exp_q.size()), 80'(0));

        // Asynchronous reset mid-cycle with a held vector and a partial fill.
        if16.out_ready = 0;
        for (int i = 0; i < 16; i++) send16(32'hC000_0000 + 32'(i), 0);
        for (int i = 0; i < 7; i++) send16(32'hD000_0000 + 32'(i), 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 80'(if16.out_valid), 80'(0));
        chk("arst_vc0", 80'(if16.vector_c[0]), 80'(0));
        chk("arst_vc15", 80'(if16.vector_c[15]), 80'(0));
        exp_q.delete();
        cur.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        if16.out_ready = 1;
        for (int i = 0; i < 16; i++) send16(32'hE000_0000 + 32'(i), 0);
        chk("post_rst_valid", 80'(if16.out_valid), 80'(1));
        chk("post_rst_count", 80'(if16.out_count), 80'(16));
        chk("post_rst_vc0", 80'(if16.vector_c[0]), 80'(32'hE000_0000));
        chk("post_rst_vc15", 80'(if16.vector_c[15]), 80'(32'hE000_000F));

        // Random traffic with random in_last, gaps and out_ready.
        rnd_mode = 1;
        for (int k = 0; k < 300; k++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
                if16.out_ready = ($urandom_range(0, 3) != 0);
            end
            send16($urandom, (k == 299) || ($urandom_range(0, 5) == 0));
        end
        rnd_mode = 0;
        if16.out_ready = 1;
        repeat (5) @(posedge clk);
        #1;
        chk("rnd_drained", 80'(exp_q.size()), 80'(0));
        chk("rnd_no_partial", 80'(cur.size()), 80'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
